// File: rtl/chip8_sprite_gpu_if.sv
// chip8_sprite_gpu_if: command and shared-memory bus for the CHIP-8 sprite blitter.
//   Command side : draw, addr, lines, x, y  -> blitter;  busy, collision <- blitter
//   Memory read  : mem_read, mem_read_idx   -> arbiter;  mem_read_byte, mem_read_ack <- arbiter
//   Memory write : mem_write, mem_write_idx, mem_write_byte -> arbiter
// slave  = the blitter itself; master = CPU core + memory arbiter side.
interface chip8_sprite_gpu_if;
  logic        draw;
  logic [11:0] addr;
  logic [3:0]  lines;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        busy;
  logic        collision;
  logic        mem_read;
  logic [11:0] mem_read_idx;
  logic [7:0]  mem_read_byte;
  logic        mem_read_ack;
  logic        mem_write;
  logic [11:0] mem_write_idx;
  logic [7:0]  mem_write_byte;

  modport slave (
    input  draw, addr, lines, x, y, mem_read_byte, mem_read_ack,
    output busy, collision, mem_read, mem_read_idx,
           mem_write, mem_write_idx, mem_write_byte
  );

  modport master (
    output draw, addr, lines, x, y, mem_read_byte, mem_read_ack,
    input  busy, collision, mem_read, mem_read_idx,
           mem_write, mem_write_idx, mem_write_byte
  );
endinterface

// File: rtl/chip8_sprite_gpu.sv
// chip8_sprite_gpu: CHIP-8 sprite blitter.
// XORs `lines` sprite bytes from memory into the 64x32 framebuffer at
// FB_BASE (8 bytes/row, bit 7 = leftmost pixel) via read-modify-write,
// and reports VF collision (any pixel turned off).
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - chip8_sprite_gpu_if.slave (command, status, memory read/write)
module chip8_sprite_gpu #(
  parameter logic [11:0] FB_BASE = 12'h100
) (
  input logic             clk,
  input logic             reset,
  chip8_sprite_gpu_if.slave bus
);

  // S_ROW evaluates the current row: end of sprite or bottom clip -> DONE.
  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_RD_SPRITE, S_RD_LEFT, S_WR_LEFT, S_RD_RIGHT, S_WR_RIGHT, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [11:0] r_addr;
  logic [3:0]  r_lines;
  logic [3:0]  r_row;
  logic [5:0]  r_x0;
  logic [4:0]  r_y0;
  logic [15:0] r_s;     // sprite byte pre-shifted into its two target bytes
  logic [7:0]  r_old;   // framebuffer byte read back for the RMW
  logic        r_coll;
  logic        r_gap;   // forces mem_read low for the cycle after an ack

  logic [5:0]  w_sy;
  logic [11:0] w_left;
  logic        w_has_right;
  logic        w_rd_state;
  logic        w_rd_req;
  logic        w_rd_done;
  logic        w_start;
  logic        w_unused;

  // 6-bit sum so rows past the bottom show up in bit 5 instead of wrapping.
  assign w_sy        = {1'b0, r_y0} + {2'b00, r_row};
  assign w_left      = FB_BASE + {4'h0, w_sy[4:0], r_x0[5:3]};
  // The right byte exists only if the sprite is misaligned and not already
  // in the last column byte; pixels past column 63 are simply dropped.
  assign w_has_right = (r_x0[2:0] != 3'd0) && (r_x0[5:3] != 3'd7);

  assign w_rd_state  = (r_state == S_RD_SPRITE) || (r_state == S_RD_LEFT) ||
                       (r_state == S_RD_RIGHT);
  assign w_rd_req    = w_rd_state && !r_gap;
  assign w_rd_done   = w_rd_req && bus.mem_read_ack;
  assign w_start     = bus.draw && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign bus.mem_read  = w_rd_req;
  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.collision = r_coll;

  // Only x mod 64 and y mod 32 matter.
  assign w_unused = &{1'b0, bus.x[7:6], bus.y[7:5]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    bus.mem_read_idx   = 12'h000;
    bus.mem_write      = 1'b0;
    bus.mem_write_idx  = 12'h000;
    bus.mem_write_byte = 8'h00;
    case (r_state)
      S_IDLE, S_DONE: w_next = bus.draw ? S_ROW : S_IDLE;
      S_ROW: begin
        if ((r_row == r_lines) || w_sy[5]) w_next = S_DONE;
        else                                w_next = S_RD_SPRITE;
      end
      S_RD_SPRITE: begin
        bus.mem_read_idx = r_addr + {8'h00, r_row};
        if (w_rd_done) w_next = S_RD_LEFT;
      end
      S_RD_LEFT: begin
        bus.mem_read_idx = w_left;
        if (w_rd_done) w_next = S_WR_LEFT;
      end
      S_WR_LEFT: begin
        bus.mem_write      = 1'b1;
        bus.mem_write_idx  = w_left;
        bus.mem_write_byte = r_old ^ r_s[15:8];
        w_next             = w_has_right ? S_RD_RIGHT : S_ROW;
      end
      S_RD_RIGHT: begin
        bus.mem_read_idx = w_left + 12'd1;
        if (w_rd_done) w_next = S_WR_RIGHT;
      end
      S_WR_RIGHT: begin
        bus.mem_write      = 1'b1;
        bus.mem_write_idx  = w_left + 12'd1;
        bus.mem_write_byte = r_old ^ r_s[7:0];
        w_next             = S_ROW;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= 12'h000;
      r_lines <= 4'h0;
      r_row   <= 4'h0;
      r_x0    <= 6'h00;
      r_y0    <= 5'h00;
      r_s     <= 16'h0000;
      r_old   <= 8'h00;
      r_coll  <= 1'b0;
      r_gap   <= 1'b0;
    end else begin
      r_gap <= w_rd_done;
      if (w_start) begin
        r_addr  <= bus.addr;
        r_lines <= bus.lines;
        r_x0    <= bus.x[5:0];
        r_y0    <= bus.y[4:0];
        r_row   <= 4'h0;
        r_coll  <= 1'b0;
      end
      if (w_rd_done) begin
        if (r_state == S_RD_SPRITE) r_s   <= {bus.mem_read_byte, 8'h00} >> r_x0[2:0];
        else                        r_old <= bus.mem_read_byte;
      end
      if (r_state == S_WR_LEFT) begin
        if ((r_old & r_s[15:8]) != 8'h00) r_coll <= 1'b1;
        if (!w_has_right)                 r_row  <= r_row + 4'd1;
      end
      if (r_state == S_WR_RIGHT) begin
        if ((r_old & r_s[7:0]) != 8'h00) r_coll <= 1'b1;
        r_row <= r_row + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_chip8_sprite_gpu.sv
// Bench for chip8_sprite_gpu: memory model with random read latency, a
// pixel-level reference model that pushes expected framebuffer writes to a
// queue, and per-scenario tasks with fixed expected values.
module tb_chip8_sprite_gpu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chip8_sprite_gpu_if bus();

  chip8_sprite_gpu #(.FB_BASE(12'h100)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [11:0] idx;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem  [4096];
  logic [7:0] fb_m [256];
  int checks = 0;
  int errors = 0;
  int wcount = 0;
  int rcnt   = 0;
  int lat    = 1;

  // Read responder: ack arrives 2..4 negedges after the request is seen.
  always @(negedge clk) begin
    bus.mem_read_ack = 1'b0;
    if (rst || bus.mem_read !== 1'b1) rcnt = 0;
    else begin
      rcnt++;
      if (rcnt > lat) begin
        bus.mem_read_ack  = 1'b1;
        bus.mem_read_byte = mem[bus.mem_read_idx];
        rcnt = 0;
        lat  = $urandom_range(1, 3);
      end
    end
  end

  // Pixel-by-pixel reference; pushes the byte writes the blitter must make.
  task automatic model_draw(input logic [11:0] a, input int n, input int xx, input int yy,
                            output logic coll);
    int x0, y0, sy, px, bi, bt, li;
    logic [7:0] b;
    wr_t w;
    x0 = xx % 64;
    y0 = yy % 32;
    coll = 1'b0;
    for (int r = 0; r < n; r++) begin
      sy = y0 + r;
      if (sy >= 32) break;
      b = mem[(int'(a) + r) % 4096];
      for (int c = 0; c < 8; c++) begin
        if (b[7-c]) begin
          px = x0 + c;
          if (px < 64) begin
            bi = sy * 8 + px / 8;
            bt = 7 - px % 8;
            if (fb_m[bi][bt]) coll = 1'b1;
            fb_m[bi][bt] = ~fb_m[bi][bt];
          end
        end
      end
      li = sy * 8 + x0 / 8;
      w.idx = 12'(256 + li); w.data = fb_m[li];
      exp_q.push_back(w);
      if ((x0 % 8 != 0) && (x0 / 8 != 7)) begin
        w.idx = 12'(256 + li + 1); w.data = fb_m[li + 1];
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic take_write(input string tag);
    wr_t e;
    checks++;
    if (bus.mem_write_idx < 12'h100 || bus.mem_write_idx > 12'h1FF) begin
      errors++;
      $display("FAIL %s write_range idx %h outside 100..1FF", tag, bus.mem_write_idx);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected_write got %h=%h exp none", tag, bus.mem_write_idx, bus.mem_write_byte);
    end else begin
      e = exp_q.pop_front();
      if (bus.mem_write_idx !== e.idx || bus.mem_write_byte !== e.data) begin
        errors++;
        $display("FAIL %s write got %h=%h exp %h=%h", tag, bus.mem_write_idx,
                 bus.mem_write_byte, e.idx, e.data);
      end
    end
    mem[bus.mem_write_idx] = bus.mem_write_byte;
    wcount++;
  endtask

  // Issue a draw from a negedge and follow it until busy drops.
  task automatic run_draw(input logic [11:0] a, input logic [3:0] n, input logic [7:0] xx,
                          input logic [7:0] yy, input string tag);
    logic ec;
    int cyc;
    model_draw(a, int'(n), int'(xx), int'(yy), ec);
    bus.addr = a; bus.lines = n; bus.x = xx; bus.y = yy; bus.draw = 1'b1;
    @(negedge clk);
    bus.draw = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s busy_start got %b exp 1", tag, bus.busy); end
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 2000) begin
      if (bus.mem_write === 1'b1) take_write(tag);
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 2000) begin errors++; $display("FAIL %s timeout busy still %b", tag, bus.busy); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s missing_writes got %0d left exp 0", tag, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (bus.collision !== ec) begin errors++; $display("FAIL %s collision got %b exp %b", tag, bus.collision, ec); end
  endtask

  task automatic check_rows(input string tag, input int base, input int step,
                            input logic [39:0] vals);
    logic [7:0] v;
    for (int i = 0; i < 5; i++) begin
      v = vals[39 - 8*i -: 8];
      checks++;
      if (mem[base + step*i] !== v) begin
        errors++; $display("FAIL %s byte %h got %h exp %h", tag, base + step*i, mem[base + step*i], v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.draw = 1'b0; bus.addr = '0; bus.lines = '0; bus.x = '0; bus.y = '0;
    bus.mem_read_ack = 1'b0; bus.mem_read_byte = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++)  fb_m[i] = 8'h00;
    mem[12'h42] = 8'hFF; mem[12'h43] = 8'hC3; mem[12'h44] = 8'hC3;
    mem[12'h45] = 8'hC3; mem[12'h46] = 8'hFF;
    #1;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b exp 0", bus.busy); end
    checks++; if (bus.collision !== 1'b0) begin errors++; $display("FAIL reset collision got %b exp 0", bus.collision); end
    checks++; if (bus.mem_read !== 1'b0)  begin errors++; $display("FAIL reset mem_read got %b exp 0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset mem_write got %b exp 0", bus.mem_write); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_box();
    run_draw(12'h042, 4'd5, 8'd0, 8'd0, "box");
    check_rows("box", 12'h100, 8, 40'hFF_C3_C3_C3_FF);
  endtask

  task automatic test_erase();
    run_draw(12'h042, 4'd5, 8'd0, 8'd0, "erase");
    checks++;
    if (bus.collision !== 1'b1) begin errors++; $display("FAIL erase vf got %b exp 1", bus.collision); end
    check_rows("erase", 12'h100, 8, 40'h0);
  endtask

  task automatic test_zero_lines();
    int busy_cyc;
    bus.addr = 12'h042; bus.lines = 4'd0; bus.x = 8'd3; bus.y = 8'd3; bus.draw = 1'b1;
    @(negedge clk);
    bus.draw = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy === 1'b1) busy_cyc++;
      checks++;
      if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
        errors++; $display("FAIL zero traffic rd %b wr %b exp 0 0", bus.mem_read, bus.mem_write);
      end
      @(negedge clk);
    end
    checks++;
    if (busy_cyc != 1) begin errors++; $display("FAIL zero busy_cycles got %0d exp 1", busy_cyc); end
    checks++;
    if (bus.collision !== 1'b0) begin errors++; $display("FAIL zero collision got %b exp 0", bus.collision); end
  endtask

  task automatic test_bottom_clip();
    run_draw(12'h042, 4'd5, 8'd0, 8'd28, "bottom");
    check_rows("bottom", 12'h1E0, 8, 40'hFF_C3_C3_C3_00);
  endtask

  task automatic test_straddle();
    run_draw(12'h042, 4'd5, 8'd5, 8'd0, "straddle");
    check_rows("straddle_l", 12'h100, 8, 40'h07_06_06_06_07);
    check_rows("straddle_r", 12'h101, 8, 40'hF8_18_18_18_F8);
  endtask

  task automatic test_right_clip();
    run_draw(12'h042, 4'd5, 8'd5, 8'd0, "unstraddle");
    run_draw(12'h042, 4'd5, 8'd61, 8'd0, "rclip");
    check_rows("rclip", 12'h107, 8, 40'h07_06_06_06_07);
    check_rows("rclip_nowrap", 12'h108, 8, 40'h0);
  endtask

  task automatic test_reset_mid();
    int w0, wseen;
    logic ec;
    model_draw(12'h042, 5, 0, 0, ec);
    bus.addr = 12'h042; bus.lines = 4'd5; bus.x = 8'd0; bus.y = 8'd0; bus.draw = 1'b1;
    @(negedge clk);
    bus.draw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_write === 1'b1) take_write("midrst");
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst pre_busy got %b exp 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrst busy got %b exp 0", bus.busy); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL midrst mem_write got %b exp 0", bus.mem_write); end
    exp_q.delete();
    w0 = wcount;
    wseen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.mem_write === 1'b1) wseen++;
    end
    checks++;
    if (wseen != 0 || wcount != w0) begin
      errors++; $display("FAIL midrst late_writes got %0d exp 0", wseen + wcount - w0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst idle_busy got %b exp 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_box();
    test_erase();
    test_zero_lines();
    test_bottom_clip();
    checks++;
    if (mem[12'h200] !== 8'h00) begin errors++; $display("FAIL bottom 200 got %h exp 00", mem[12'h200]); end
    test_straddle();
    test_right_clip();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_sprite_gpu.md
Name: chip8_sprite_gpu

Overview:
- CHIP-8 sprite blitter.
- On a draw command it reads `lines` sprite bytes from main memory and XORs them into the 64x32 monochrome framebuffer held in the same memory at 0x100–0x1FF.
- Framebuffer layout: 8 bytes per row; bit 7 of a byte is the leftmost pixel.
- Reports CHIP-8 VF collision (any pixel turned off). Sits between the CPU core and the shared memory arbiter.

Parameters:
- FB_BASE, 12'h100, framebuffer base address.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- draw  in  1  one-cycle start strobe; ignored while busy
- addr  in  12  sprite source address
- lines  in  4  sprite height in rows (0–15)
- x  in  8  start column; used modulo 64
- y  in  8  start row; used modulo 32
- busy  out  1  high while a draw is in progress
- collision  out  1  result of last draw; valid when busy low
- mem_read  out  1  read request
- mem_read_idx  out  12  read address
- mem_read_byte  in  8  read data
- mem_read_ack  in  1  read data valid this cycle
- mem_write  out  1  write strobe; one cycle per byte
- mem_write_idx  out  12  write address
- mem_write_byte  out  8  write data

Behaviour:
- Reset (async): state IDLE; busy, collision, mem_read, mem_write = 0; any in-progress draw is abandoned with no further writes.
- IDLE: when draw=1, latch addr, lines, x0=x[5:0], y0=y[4:0], row=0. Clear collision, set busy=1 at the next edge, so busy is high in the cycle after draw is sampled.
- Per row r (0..lines-1):
  - Screen row sy = y0+r, computed 6-bit, no wrap.
  - If sy>=32: the row and all remaining rows are skipped (bottom clip); go to DONE.
  - Otherwise, read the sprite byte at addr+r (12-bit wrap).
  - Form the 16-bit value S = {byte,8'h00} >> x0[2:0].
  - Left target = FB_BASE + sy*8 + x0[5:3].
  - Right target = left target + 1, used only when x0[2:0]!=0 and x0[5:3]!=7. No right-edge wrap; bits past column 63 are dropped.
- Each target byte is a read-modify-write: read old, write old ^ part (part = S[15:8] for left, S[7:0] for right). Set collision if (old & part)!=0.
- Read handshake:
  - Hold mem_read=1 with a stable mem_read_idx until a cycle with mem_read_ack=1.
  - Sample mem_read_byte in that cycle and deassert mem_read the next cycle.
  - The memory acks one or more cycles after the request.
- Write: mem_write=1 for exactly one cycle with idx/byte valid. Memory commits at that edge, and a subsequent read returns the new value.
- States: IDLE → RD_SPRITE → RD_LEFT → WR_LEFT → [RD_RIGHT → WR_RIGHT] → next row or DONE.
- DONE: busy=0, collision held, return to IDLE.
- lines=0: no memory traffic; busy high for exactly one cycle; collision=0.
- Only FB_BASE..FB_BASE+0xFF and sprite addresses are accessed. Never write outside the framebuffer.

Test Plan:
- Memory 0x42..0x46 = FF,C3,C3,C3,FF, framebuffer cleared; draw(0x42,5,0,0) → collision=0; 0x100=FF, 0x108=C3, 0x110=C3, 0x118=C3, 0x120=FF.
- Repeat the same draw → collision=1; the same five bytes all 00.
- draw(0x42,5,0,28) → collision=0; 0x1E0=FF, 0x1E8/0x1F0/0x1F8=C3; 0x200 unchanged (00), no write above 0x1FF.
- draw(0x42,5,5,0) → pairs (0x100,0x101)=07,F8; rows 1–3 = 06,18; row 4 = 07,F8; collision=0.
- Erase with the same draw, then draw(0x42,5,61,0) → 0x107=07, 0x10F/0x117/0x11F=06, 0x127=07; 0x108/0x110/0x118/0x120/0x128 = 00 (no wrap); collision=0.
- Assert reset mid-draw → busy=0 and mem_write=0 immediately; no further writes. draw(…,lines=0) → one busy cycle, collision=0.
